// File: rtl/gray_to_binary_dec.sv
// gray_to_binary_dec: registered Gray-to-binary decoder with valid/ready on
// both sides and a single output register (full throughput, 1-cycle latency).
// Optional step checker enabled by defining GRAY_STEP_CHECK_EN: flags accepted
// words whose Gray code differs from the previous accepted word in more than
// one bit, and keeps a saturating count of such events. Without the macro,
// step_err and err_cnt are tied to 0 and no history registers are built.
module gray_to_binary_dec #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_bin,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic             accept;
  logic             emit;
  logic [WIDTH-1:0] dec_bin;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_bin_q, out_bin_d;

  // Output register is free when empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid_q && out_ready;

  // Each binary bit is the parity of the Gray bits at and above it.
  always_comb begin
    dec_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec_bin[i] = ^(in_gray >> i);
    end
  end

  // Next state of the output register: load on accept, drop valid on a bare emit.
  always_comb begin
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_bin_d   = dec_bin;
    end else if (emit) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;

`ifdef GRAY_STEP_CHECK_EN
  localparam logic [WIDTH-1:0]     ONE_W   = WIDTH'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     prev_gray_q, prev_gray_d;
  logic                 have_prev_q, have_prev_d;
  logic                 step_err_q, step_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]     diff;
  logic                 multi_bit;
  logic                 step_flag;

  // More than one differing bit <=> clearing the lowest set bit leaves something.
  assign diff      = in_gray ^ prev_gray_q;
  assign multi_bit = |(diff & (diff - ONE_W));
  assign step_flag = have_prev_q && multi_bit;

  // Checker next state: history and flag update only on accept.
  always_comb begin
    prev_gray_d = prev_gray_q;
    have_prev_d = have_prev_q;
    step_err_d  = step_err_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      prev_gray_d = in_gray;
      have_prev_d = 1'b1;
      step_err_d  = step_flag;
      if (step_flag && (err_cnt_q != CNT_MAX)) begin
        err_cnt_d = err_cnt_q + CNT_ONE;
      end
    end
  end

  // Checker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray_q <= '0;
      have_prev_q <= 1'b0;
      step_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      prev_gray_q <= prev_gray_d;
      have_prev_q <= have_prev_d;
      step_err_q  <= step_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;
`else
  assign step_err = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_gray_to_binary_dec.sv
// Scoreboard bench for gray_to_binary_dec (WIDTH=4, ERR_CNT_W=2).
// Step-error expectations apply only when GRAY_STEP_CHECK_EN is defined;
// otherwise step_err and err_cnt are expected to stay 0.
module tb_gray_to_binary_dec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_gray = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_bin;
  logic       step_err;
  logic [1:0] err_cnt;

  typedef struct packed {
    logic [3:0] bin;
    logic       err;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  gray_to_binary_dec #(.WIDTH(4), .ERR_CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .step_err  (step_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever the DUT hands off a word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got bin %0d expected no output", out_bin);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_bin", int'(out_bin), int'(e.bin));
        chk("step_err", int'(step_err), int'(e.err));
        chk("err_cnt", int'(err_cnt), int'(e.cnt));
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bin", int'(out_bin), 0);
    chk("rst_step_err", int'(step_err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drive one word and wait (bounded) for it to be accepted.
  task automatic send(input logic [3:0] g, input logic [3:0] b,
                      input logic e, input logic [1:0] c);
    bit   acc;
    exp_t x;
    acc = 1'b0;
`ifndef GRAY_STEP_CHECK_EN
    e = 1'b0;
    c = 2'd0;
`endif
    in_valid = 1'b1;
    in_gray  = g;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        x = '{bin: b, err: e, cnt: c};
        sb.push_back(x);
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready 0 expected accept of gray %0d", g);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_gray = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    do_reset();

    // Counting sequence, full throughput.
    send(4'b0000, 4'd0, 1'b0, 2'd0);
    send(4'b0001, 4'd1, 1'b0, 2'd0);
    send(4'b0011, 4'd2, 1'b0, 2'd0);
    send(4'b0010, 4'd3, 1'b0, 2'd0);
    send(4'b0110, 4'd4, 1'b0, 2'd0);
    idle(3);

    // Single word, out_valid for exactly one cycle.
    do_reset();
    send(4'b1000, 4'b1111, 1'b0, 2'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("single_valid_first", int'(out_valid), 1);
    @(negedge clk);
    chk("single_valid_after", int'(out_valid), 0);
    idle(2);

    // Backpressure: output held, in_ready low, then drain and accept together.
    do_reset();
    out_ready = 1'b0;
    send(4'b0110, 4'b0100, 1'b0, 2'd0);
    in_valid = 1'b1;
    in_gray  = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_bin", int'(out_bin), 4);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(4'b0111, 4'b0101, 1'b0, 2'd0);
    idle(3);

    // Step checker: jump, legal step, jump into max, wrap to zero.
    do_reset();
    send(4'b0000, 4'd0,    1'b0, 2'd0);
    send(4'b0011, 4'd2,    1'b1, 2'd1);
    send(4'b0010, 4'd3,    1'b0, 2'd1);
    send(4'b1000, 4'b1111, 1'b1, 2'd2);
    send(4'b0000, 4'd0,    1'b0, 2'd2);
    idle(3);

    // Saturation of the 2-bit error counter.
    do_reset();
    send(4'b0000, 4'd0, 1'b0, 2'd0);
    send(4'b0011, 4'd2, 1'b1, 2'd1);
    send(4'b0000, 4'd0, 1'b1, 2'd2);
    send(4'b0011, 4'd2, 1'b1, 2'd3);
    send(4'b0000, 4'd0, 1'b1, 2'd3);
    send(4'b0011, 4'd2, 1'b1, 2'd3);
    idle(3);

    // Reset while a word is stalled in the output register.
    do_reset();
    send(4'b0000, 4'd0, 1'b0, 2'd0);
    send(4'b0011, 4'd2, 1'b1, 2'd1);
    idle(2);
    out_ready = 1'b0;
    send(4'b0000, 4'd0, 1'b1, 2'd2);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_out_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_err_cnt", int'(err_cnt), 0);
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'b1111, 4'b1010, 1'b0, 2'd0);
    idle(4);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gray_to_binary_dec.md
Name: gray_to_binary_dec

Overview:
- Registered Gray-to-binary decoder with valid/ready handshake on both sides.
- Receive-side counterpart of the team's Gray encoder. Turns Gray-coded words (counters, synchronized pointers) back into binary.
- Optional checker flags accepted words that move by more than one bit from the previous word.

Parameters:
- WIDTH, 4, bit width of the Gray input and binary output; legal range 2..32.
- ERR_CNT_W, 8, width of the saturating step-error counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_gray holds a valid word.
- in_ready  output  1  block can accept a word this cycle.
- in_gray  input  WIDTH  Gray-coded input word.
- out_valid  output  1  out_bin holds a decoded word.
- out_ready  input  1  downstream accepts out_bin this cycle.
- out_bin  output  WIDTH  decoded binary word.
- step_err  output  1  qualified by out_valid; current word violated the single-step rule.
- err_cnt  output  ERR_CNT_W  saturating count of step errors since reset.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_bin=0, step_err=0, err_cnt=0.
  - Internal prev_gray=0, have_prev=0.
- Decode rule:
  - b[WIDTH-1]=g[WIDTH-1].
  - b[i]=b[i+1]^g[i] for i=WIDTH-2 down to 0.
  - Pure XOR prefix; no arithmetic, no overflow.
- Handshake:
  - Accept when in_valid && in_ready.
  - Emit when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). Single output register, full throughput.
- Latency: exactly 1 cycle. Word accepted at edge N appears on out_bin with out_valid=1 after edge N.
- Output register update on each edge:
  - Accept → out_bin/step_err load the new word; out_valid=1.
  - Emit without accept → out_valid=0. out_bin holds its last value.
  - Neither → all outputs hold.
  - Emit and accept in the same cycle → new word replaces the old one; out_valid stays 1.
- Stability: while out_valid=1 and out_ready=0, out_bin and step_err must not change. in_ready=0 in this state.
- Input rules:
  - in_gray is sampled only on accept.
  - Values when in_valid=0 are don't-care and must not affect state.
- Reset mid-operation: any in-flight word is dropped; history and err_cnt are cleared.
- All-ones / wrap-around values decode per the rule. Example, WIDTH=4: Gray 1000 → binary 1111.

Optional Feature:
- Macro GRAY_STEP_CHECK_EN.
- Defined:
  - On each accept, compute Hamming distance between in_gray and prev_gray.
  - If have_prev=1 and distance>1: step_err loads 1 and err_cnt increments, saturating at 2^ERR_CNT_W-1.
  - Otherwise step_err loads 0.
  - Distance 0 (repeated word) is legal.
  - After the check, prev_gray=in_gray and have_prev=1.
  - The first word after reset is never flagged.
  - Wrap from max Gray to 0 is a one-bit change and is legal. Example, WIDTH=4: 1000 → 0000.
- Not defined:
  - step_err and err_cnt are constant 0.
  - No prev_gray or have_prev registers are built.
  - Ports remain present.

Test Plan:
- Reset then in_valid=1 with in_gray 0000, 0001, 0011, 0010, 0110 on consecutive cycles, out_ready=1 → out_bin 0,1,2,3,4 one cycle later each; in_ready stays 1; step_err=0.
- Single word in_gray=1000, then in_valid=0 → out_bin=1111, out_valid=1 for exactly one cycle.
- Backpressure:
  - Accept Gray 0110, then hold out_ready=0 for 3 cycles while in_valid=1 with in_gray=0111.
  - Required: out_bin stays 0100; in_ready=0 for those 3 cycles.
  - Raise out_ready: 0100 is emitted; 0111 is accepted the same cycle and appears as 0101 next cycle.
- With GRAY_STEP_CHECK_EN:
  - Words 0000 then 0011 → second output has step_err=1, err_cnt=1.
  - Next word 0010 → step_err=0, err_cnt=1.
  - Wrap 1000 → 0000 is not flagged.
- With GRAY_STEP_CHECK_EN, ERR_CNT_W=2: 5 consecutive two-bit jumps (0000, 0011, 0000, 0011, 0000, 0011) → err_cnt saturates at 3.
- Assert rst_n=0 while out_valid=1 and out_ready=0 → out_valid=0, err_cnt=0 immediately. After release, first word 1111 → out_bin=1010, step_err=0.
